fft_frame_buffer: RTL and testbench

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

---
 rtl/fft_pkg.sv | 29 ++
 rtl/sample_decimator.sv | 44 ++++
 rtl/fft_frame_buffer.sv | 157 +++++++++++++++
 tb/tb_fft_frame_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front end: frame geometry, issue FSM states
// and the radix-2 twiddle table used by the FFT stage.
package fft_pkg;

  localparam int unsigned FFT_N            = 16;
  localparam int unsigned FFT_DATA_W       = 16;
  localparam int unsigned FFT_GUARD_CYCLES = 5;
  localparam int unsigned FFT_IDX_W        = $clog2(FFT_N);
  localparam int unsigned FFT_GUARD_W      = $clog2(FFT_GUARD_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGuard
  } issue_state_e;

  typedef logic [FFT_DATA_W-1:0] fft_word_t;

  // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q1.15, k = 0..7
  localparam logic signed [15:0] FFT_TWIDDLE_RE [FFT_N/2] = '{
    16'sd32767, 16'sd30273, 16'sd23170, 16'sd12540,
    16'sd0, -16'sd12540, -16'sd23170, -16'sd30273
  };
  localparam logic signed [15:0] FFT_TWIDDLE_IM [FFT_N/2] = '{
    16'sd0, -16'sd12540, -16'sd23170, -16'sd30273,
    -16'sd32767, -16'sd30273, -16'sd23170, -16'sd12540
  };

endpackage

// File: rtl/sample_decimator.sv
// Keeps one valid sample in every DECIM and truncates it to the FFT word width.
module sample_decimator
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned DECIM    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [SAMPLE_W-1:0]   data_i,
  output logic                  keep_o,
  output logic [FFT_DATA_W-1:0] data_o
);

  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_i) begin
      cnt_d = (cnt_q == CntW'(DECIM - 1)) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign keep_o = valid_i && (cnt_q == '0);
  // Plain truncation: the low bits are dropped without rounding.
  assign data_o = data_i[SAMPLE_W-1 -: FFT_DATA_W];

  if (SAMPLE_W > FFT_DATA_W) begin : g_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^data_i[SAMPLE_W-FFT_DATA_W-1:0];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Collects kept samples into 16-sample frames and hands each frame to the FFT stage
// with a one-cycle new_t pulse, followed by a guard interval for the FFT to finish.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned DECIM    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_in,
  output logic [FFT_DATA_W-1:0] t0,
  output logic [FFT_DATA_W-1:0] t1,
  output logic [FFT_DATA_W-1:0] t2,
  output logic [FFT_DATA_W-1:0] t3,
  output logic [FFT_DATA_W-1:0] t4,
  output logic [FFT_DATA_W-1:0] t5,
  output logic [FFT_DATA_W-1:0] t6,
  output logic [FFT_DATA_W-1:0] t7,
  output logic [FFT_DATA_W-1:0] t8,
  output logic [FFT_DATA_W-1:0] t9,
  output logic [FFT_DATA_W-1:0] t10,
  output logic [FFT_DATA_W-1:0] t11,
  output logic [FFT_DATA_W-1:0] t12,
  output logic [FFT_DATA_W-1:0] t13,
  output logic [FFT_DATA_W-1:0] t14,
  output logic [FFT_DATA_W-1:0] t15,
  output logic                  new_t,
  output logic                  overrun
);

  logic      keep;
  fft_word_t keep_data;

  sample_decimator #(
    .SAMPLE_W (SAMPLE_W),
    .DECIM    (DECIM)
  ) u_decim (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (sample_valid),
    .data_i  (sample_in),
    .keep_o  (keep),
    .data_o  (keep_data)
  );

  fft_word_t              cap_q       [FFT_N];
  fft_word_t              pend_frame_q[FFT_N];
  fft_word_t              out_frame_q [FFT_N];
  logic [FFT_IDX_W-1:0]   wr_idx_q;
  logic                   pend_q;
  logic                   overrun_q;
  logic                   new_t_q;
  issue_state_e           state_q;
  logic [FFT_GUARD_W-1:0] guard_cnt_q;
  logic                   frame_done;
  logic                   consume;

  assign frame_done = keep && (wr_idx_q == FFT_IDX_W'(FFT_N - 1));
  assign consume    = (state_q == StIdle) && pend_q;

  // Data-only storage; never observable before being fully rewritten.
  always_ff @(posedge clk) begin
    if (keep) begin
      cap_q[wr_idx_q] <= keep_data;
    end
  end

  // The completing slot-15 sample bypasses the capture buffer into the snapshot.
  always_ff @(posedge clk) begin
    if (frame_done) begin
      for (int i = 0; i < FFT_N - 1; i++) begin
        pend_frame_q[i] <= cap_q[i];
      end
      pend_frame_q[FFT_N-1] <= keep_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_q  <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (keep) begin
        wr_idx_q <= wr_idx_q + FFT_IDX_W'(1);
      end
      if (frame_done) begin
        // A frame landing on the consume edge replaces pend cleanly, not an overrun.
        pend_q <= 1'b1;
        if (pend_q && !consume) begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      guard_cnt_q <= '0;
      new_t_q     <= 1'b0;
      for (int i = 0; i < FFT_N; i++) begin
        out_frame_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            state_q <= StIssue;
            new_t_q <= 1'b1;
            for (int i = 0; i < FFT_N; i++) begin
              out_frame_q[i] <= pend_frame_q[i];
            end
          end
        end
        StIssue: begin
          state_q     <= StGuard;
          new_t_q     <= 1'b0;
          guard_cnt_q <= FFT_GUARD_W'(FFT_GUARD_CYCLES - 1);
        end
        StGuard: begin
          if (guard_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            guard_cnt_q <= guard_cnt_q - FFT_GUARD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign new_t   = new_t_q;
  assign overrun = overrun_q;

  assign t0  = out_frame_q[0];
  assign t1  = out_frame_q[1];
  assign t2  = out_frame_q[2];
  assign t3  = out_frame_q[3];
  assign t4  = out_frame_q[4];
  assign t5  = out_frame_q[5];
  assign t6  = out_frame_q[6];
  assign t7  = out_frame_q[7];
  assign t8  = out_frame_q[8];
  assign t9  = out_frame_q[9];
  assign t10 = out_frame_q[10];
  assign t11 = out_frame_q[11];
  assign t12 = out_frame_q[12];
  assign t13 = out_frame_q[13];
  assign t14 = out_frame_q[14];
  assign t15 = out_frame_q[15];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed self-checking bench for fft_frame_buffer: one DECIM=1 and one DECIM=4 instance.
module tb_fft_frame_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sv_a, sv_b;
  logic [23:0] in_a, in_b;
  logic [15:0] t_a [16];
  logic [15:0] t_b [16];
  logic        new_t_a, new_t_b, ovr_a, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_frame_buffer #(.SAMPLE_W(24), .DECIM(1)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sv_a), .sample_in(in_a),
    .t0(t_a[0]), .t1(t_a[1]), .t2(t_a[2]), .t3(t_a[3]),
    .t4(t_a[4]), .t5(t_a[5]), .t6(t_a[6]), .t7(t_a[7]),
    .t8(t_a[8]), .t9(t_a[9]), .t10(t_a[10]), .t11(t_a[11]),
    .t12(t_a[12]), .t13(t_a[13]), .t14(t_a[14]), .t15(t_a[15]),
    .new_t(new_t_a), .overrun(ovr_a)
  );

  fft_frame_buffer #(.SAMPLE_W(24), .DECIM(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_valid(sv_b), .sample_in(in_b),
    .t0(t_b[0]), .t1(t_b[1]), .t2(t_b[2]), .t3(t_b[3]),
    .t4(t_b[4]), .t5(t_b[5]), .t6(t_b[6]), .t7(t_b[7]),
    .t8(t_b[8]), .t9(t_b[9]), .t10(t_b[10]), .t11(t_b[11]),
    .t12(t_b[12]), .t13(t_b[13]), .t14(t_b[14]), .t15(t_b[15]),
    .new_t(new_t_b), .overrun(ovr_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive count back-to-back samples (base+i) << 8 into the DECIM=1 instance.
  task automatic feed_a(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      sv_a = 1'b1;
      in_a = {16'(base + i), 8'h00};
      tick();
    end
    sv_a = 1'b0;
  endtask

  task automatic wait_pulse_a(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (new_t_a) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input bit sel_b, input int base, input int step);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("%s t%0d", tag, k), sel_b ? t_b[k] : t_a[k], 32'(base + step * k));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " new_t"}, new_t_a, 0);
    check_val({tag, " overrun"}, ovr_a, 0);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("%s t%0d", tag, k), t_a[k], 0);
    end
    check_val({tag, " dut4 new_t"}, new_t_b, 0);
    check_val({tag, " dut4 t15"}, t_b[15], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, p1, p2, n, pk, highs, found;
    logic [15:0] f0_first, f0_last;

    reset_n = 1'b1;
    sv_a = 1'b0; sv_b = 1'b0; in_a = '0; in_b = '0;
    #1 reset_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    check_val("no pulse after release", new_t_a, 0);

    // Sparse samples, one every 4th cycle: t_k = k+1.
    np = 0; pk = -1;
    for (int k = 1; k <= 16; k++) begin
      sv_a = 1'b1; in_a = {16'(k), 8'h00}; tick(); sv_a = 1'b0;
      if (new_t_a) np++;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (new_t_a) begin np++; pk = k; end
      end
    end
    check_val("sparse pulse count", np, 1);
    check_val("sparse pulse after 16th", pk, 16);
    check_frame("sparse", 1'b0, 1, 1);
    check_val("sparse overrun", ovr_a, 0);
    repeat (8) tick();

    // 32 back-to-back samples: two frames, 16 cycles apart.
    np = 0; p1 = -1; p2 = -1; f0_first = '0; f0_last = '0;
    for (int c = 0; c < 40; c++) begin
      sv_a = (c < 32); in_a = {16'(16'h40 + c), 8'h00}; tick();
      if (new_t_a) begin
        np++;
        if (p1 < 0) begin p1 = c; f0_first = t_a[0]; f0_last = t_a[15]; end
        else p2 = c;
      end
    end
    sv_a = 1'b0;
    check_val("b2b pulse count", np, 2);
    check_val("b2b pulse spacing", p2 - p1, 16);
    check_val("b2b frame0 t0", f0_first, 16'h40);
    check_val("b2b frame0 t15", f0_last, 16'h4F);
    check_frame("b2b frame1", 1'b0, 16'h50, 1);
    check_val("b2b overrun", ovr_a, 0);

    // DECIM=4, samples 0..63: keeps 0,4,..,60.
    np = 0;
    for (int s = 0; s < 70; s++) begin
      sv_b = (s < 64); in_b = {16'(s), 8'h00}; tick();
      if (new_t_b) np++;
    end
    sv_b = 1'b0;
    check_val("decim4 pulse count", np, 1);
    check_frame("decim4", 1'b1, 0, 4);
    check_val("decim4 overrun", ovr_b, 0);

    // Reset mid-frame, then reset during GUARD.
    feed_a(16'h70, 10);
    reset_n = 1'b0;
    #1 check_reset_outputs("reset midframe");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_val("midframe no pulse after release", new_t_a, 0);
    feed_a(16'h80, 16);
    wait_pulse_a(4, n);
    check_val("post-reset pulse seen", n > 0, 1);
    check_frame("post-reset", 1'b0, 16'h80, 1);
    tick(); tick();
    reset_n = 1'b0;
    #1 check_reset_outputs("reset guard");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_val("guard no pulse after release", new_t_a, 0);
    feed_a(16'h90, 16);
    wait_pulse_a(4, n);
    check_val("post-guard-reset pulse seen", n > 0, 1);
    check_frame("post-guard-reset", 1'b0, 16'h90, 1);
    repeat (8) tick();

    // Frame completion on the edge that enters ISSUE.
    feed_a(16'hA0, 16);
    wait_pulse_a(4, n);
    check_val("coinc frame0 pulse seen", n > 0, 1);
    tick();
    force dut.guard_cnt_q = 3'd4;
    feed_a(16'hB0, 16);
    feed_a(16'hC0, 15);
    release dut.guard_cnt_q;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dut.guard_cnt_q == 3'd0) begin found = 1; break; end
    end
    check_val("coinc guard sync", found, 1);
    tick();
    check_val("coinc idle no pulse", new_t_a, 0);
    sv_a = 1'b1; in_a = {16'hC0 + 16'd15, 8'h00}; tick(); sv_a = 1'b0;
    check_val("coinc issue pulse", new_t_a, 1);
    check_frame("coinc issued", 1'b0, 16'hB0, 1);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (new_t_a) highs++;
    end
    check_val("coinc gap quiet", highs, 0);
    tick();
    check_val("coinc second pulse", new_t_a, 1);
    check_frame("coinc second", 1'b0, 16'hC0, 1);
    check_val("coinc overrun", ovr_a, 0);
    repeat (8) tick();

    // Overrun: two frames complete while pend is held by a stretched GUARD.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    feed_a(16'hD0, 16);
    wait_pulse_a(4, n);
    check_val("ovr frame0 pulse seen", n > 0, 1);
    tick();
    force dut.guard_cnt_q = 3'd4;
    feed_a(16'hE0, 16);
    check_val("ovr after first pending", ovr_a, 0);
    feed_a(16'hF0, 16);
    check_val("ovr after second pending", ovr_a, 1);
    release dut.guard_cnt_q;
    wait_pulse_a(12, n);
    check_val("ovr issue pulse seen", n > 0, 1);
    check_frame("ovr newest", 1'b0, 16'hF0, 1);
    np = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (new_t_a) np++;
    end
    check_val("ovr no extra pulse", np, 0);
    check_val("ovr sticky", ovr_a, 1);
    reset_n = 1'b0;
    #1 check_val("ovr cleared by reset", ovr_a, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
